// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage, the synchronous instruction ROM and the core.
// The master side belongs to instr_fetch; the slave side belongs to the ROM/core environment.
interface instr_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_q;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [31:0]           instr_pc;
  logic                  halted;

  modport master (
    output rom_addr,
    input  rom_q,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr_data,
    output instr_pc,
    output halted
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    input  instr_pc,
    input  halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: issues sequential ROM reads, absorbs the one-cycle ROM latency and
// buffers returned words in a DEPTH-entry prefetch FIFO drained by a valid/ready handshake.
module instr_fetch #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] LAST_PC    = 32'd7
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  localparam int unsigned   CW        = $clog2(DEPTH + 1);
  localparam int unsigned   OW        = CW + 1;
  localparam int unsigned   PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OW-1:0] DEPTH_O   = OW'(DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

  logic [31:0]           fetch_pc_q, fetch_pc_d;
  logic                  done_q, done_d;
  logic                  inflight_valid_q, inflight_valid_d;
  logic [31:0]           inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           fifo_pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [31:0]           hold_pc_q;
  logic [DATA_WIDTH-1:0] hold_data_q;

  logic                  head_valid;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [OW-1:0]         occupancy;
  logic [31:0]           out_pc;
  logic [DATA_WIDTH-1:0] out_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count_q != '0);
  assign pop        = head_valid && bus.instr_ready;
  assign push       = inflight_valid_q && !bus.redirect_valid;

  // Credit check counts the read still in flight so a returning word always has a slot.
  assign occupancy  = OW'(count_q) - OW'(pop) + OW'(inflight_valid_q);
  assign issue      = !bus.redirect_valid && !done_q && (occupancy < DEPTH_O);

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    done_d           = done_q;
    inflight_valid_d = issue;
    inflight_pc_d    = inflight_pc_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;

    if (bus.redirect_valid) begin
      fetch_pc_d       = bus.redirect_pc;
      done_d           = (bus.redirect_pc > LAST_PC);
      inflight_valid_d = 1'b0;
      rd_ptr_d         = '0;
      wr_ptr_d         = '0;
      count_d          = '0;
    end else begin
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd1;
        if (fetch_pc_q == LAST_PC) begin
          done_d = 1'b1;
        end
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q       <= '0;
      done_q           <= 1'b0;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      done_q           <= done_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else if (push) begin
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
      fifo_data_q[wr_ptr_q] <= bus.rom_q;
    end
  end

  // Shadow of whatever was last presented, so the outputs freeze when the FIFO drains or is flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_pc_q   <= '0;
      hold_data_q <= '0;
    end else begin
      hold_pc_q   <= out_pc;
      hold_data_q <= out_data;
    end
  end

  assign out_pc   = head_valid ? fifo_pc_q[rd_ptr_q]   : hold_pc_q;
  assign out_data = head_valid ? fifo_data_q[rd_ptr_q] : hold_data_q;

  assign bus.rom_addr    = fetch_pc_q[ADDR_WIDTH-1:0];
  assign bus.instr_valid = head_valid;
  assign bus.instr_pc    = out_pc;
  assign bus.instr_data  = out_data;
  assign bus.halted      = done_q && !inflight_valid_q && !head_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM model returns 0x100+addr one cycle after the address.
module tb_instr_fetch;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  instr_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (2),
    .LAST_PC   (32'd7)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_q <= 32'h100 + 32'(bus.rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, "_pc"}, bus.instr_pc, pc);
    chk({tag, "_data"}, bus.instr_data, 32'h100 + pc);
  endtask

  task automatic chk_empty(input string tag, input logic halted_exp);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_halted"}, 32'(bus.halted), 32'(halted_exp));
  endtask

  initial begin
    int e;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_data", bus.instr_data, 32'd0);
    chk("rst_pc", bus.instr_pc, 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_romaddr", 32'(bus.rom_addr), 32'd0);

    // Test 1: free-running stream pc 0..7, then halt
    rst_n = 1'b1;
    chk_empty("t1_lat0", 1'b0);
    @(negedge clk);
    chk_empty("t1_lat1", 1'b0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk_head("t1_stream", 32'(i));
      e = (i + 2 > 8) ? 8 : i + 2;
      chk("t1_romaddr", 32'(bus.rom_addr), 32'(e & 7));
      chk("t1_not_halted", 32'(bus.halted), 32'd0);
      @(negedge clk);
    end
    chk_empty("t1_done", 1'b1);
    chk("t1_hold_pc", bus.instr_pc, 32'd7);
    chk("t1_hold_data", bus.instr_data, 32'h107);
    chk("t1_romaddr_stop", 32'(bus.rom_addr), 32'd0);
    @(negedge clk);
    chk_empty("t1_stay", 1'b1);
    chk("t1_romaddr_stay", 32'(bus.rom_addr), 32'd0);

    // Test 5: redirect to 0 while halted, core stalled
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd0;
    bus.instr_ready    = 1'b0;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk_empty("t5_r1", 1'b0);
    @(negedge clk);
    chk_empty("t5_r2", 1'b0);
    @(negedge clk);

    // Test 2: stall six cycles from the first valid word
    for (int k = 0; k < 6; k++) begin
      chk_head("t2_stall", 32'd0);
      chk("t2_no_issue", 32'(bus.rom_addr), 32'd2);
      @(negedge clk);
    end
    chk_head("t2_release", 32'd0);
    chk("t2_romaddr", 32'(bus.rom_addr), 32'd2);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk_head("t2_drain1", 32'd1);
    @(negedge clk);
    chk_head("t2_drain2", 32'd2);

    // Test 3: redirect to 5 while pc 2 is popped
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd5;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk_empty("t3_r1", 1'b0);
    chk("t3_hold_pc", bus.instr_pc, 32'd2);
    chk("t3_hold_data", bus.instr_data, 32'h102);
    chk("t3_romaddr", 32'(bus.rom_addr), 32'd5);
    @(negedge clk);
    chk_empty("t3_r2", 1'b0);
    @(negedge clk);
    chk_head("t3_pc5", 32'd5);
    @(negedge clk);
    chk_head("t3_pc6", 32'd6);
    @(negedge clk);
    chk_head("t3_pc7", 32'd7);
    @(negedge clk);
    chk_empty("t3_halt", 1'b1);

    // Test 4: restart, then redirect beyond LAST_PC mid-stream
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd0;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_head("t4_pc0", 32'd0);
    @(negedge clk);
    chk_head("t4_pc1", 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd9;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk_empty("t4_halt", 1'b1);
    chk("t4_hold_pc", bus.instr_pc, 32'd1);
    chk("t4_hold_data", bus.instr_data, 32'h101);
    chk("t4_romaddr", 32'(bus.rom_addr), 32'd1);
    @(negedge clk);
    chk_empty("t4_stay", 1'b1);
    chk("t4_no_issue", 32'(bus.rom_addr), 32'd1);

    // Test 6: asynchronous reset with the buffer full
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd3;
    bus.instr_ready    = 1'b0;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_head("t6_pc3", 32'd3);
    @(negedge clk);
    chk_head("t6_full", 32'd3);
    chk("t6_romaddr", 32'(bus.rom_addr), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.instr_valid), 32'd0);
    chk("t6_async_halted", 32'(bus.halted), 32'd0);
    chk("t6_async_pc", bus.instr_pc, 32'd0);
    chk("t6_async_data", bus.instr_data, 32'd0);
    chk("t6_async_romaddr", 32'(bus.rom_addr), 32'd0);
    @(negedge clk);
    rst_n           = 1'b1;
    bus.instr_ready = 1'b1;
    chk_empty("t6_lat0", 1'b0);
    @(negedge clk);
    chk_empty("t6_lat1", 1'b0);
    @(negedge clk);
    chk_head("t6_pc0", 32'd0);
    @(negedge clk);
    chk_head("t6_pc1", 32'd1);
    @(negedge clk);
    chk_head("t6_pc2", 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage between the CPU core and the synchronous instruction ROM. It generates sequential ROM addresses and absorbs the ROM's one-cycle read latency. A DEPTH-entry prefetch buffer holds the returned words, which the core takes through a valid/ready handshake. The core can redirect fetch to a new PC, for example on a branch. Fetch stops after LAST_PC has been issued.

Parameters:
ADDR_WIDTH, 3, ROM address width; rom_addr = fetch_pc[ADDR_WIDTH-1:0]
DATA_WIDTH, 32, instruction word width
DEPTH, 2, prefetch buffer entries (>=2)
LAST_PC, 7, last word address fetched before stopping

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rom_addr  output  ADDR_WIDTH  ROM read address, sampled by ROM at rising edge
rom_q  input  DATA_WIDTH  ROM read data, valid the cycle after address sampled
redirect_valid  input  1  load redirect_pc and flush, sampled at edge
redirect_pc  input  32  new fetch word address
instr_valid  output  1  buffer head holds a valid instruction
instr_ready  input  1  core accepts head; pop = instr_valid & instr_ready
instr_data  output  DATA_WIDTH  head instruction word
instr_pc  output  32  word address of head instruction
halted  output  1  fetch stopped, buffer empty, nothing in flight

Behaviour:
- Reset, asynchronous on rst_n low, clears state immediately:
  - fetch_pc=0, done=0, inflight_valid=0, buffer empty.
  - Outputs: instr_valid=0, instr_data=0, instr_pc=0, halted=0, rom_addr=0.
- Internal state:
  - fetch_pc: 32 bits.
  - done: set once LAST_PC has been issued.
  - inflight_valid / inflight_pc: one outstanding ROM read.
  - FIFO: DEPTH entries of {pc, data}, plus count.
- Issue condition (combinational, cycle N): !redirect_valid & !done & ((count - pop) + inflight_valid < DEPTH).
- On issue:
  - rom_addr = fetch_pc[ADDR_WIDTH-1:0].
  - At edge: inflight_valid<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1.
  - done<=1 if fetch_pc==LAST_PC.
- No issue: inflight_valid<=0 at edge. rom_addr keeps fetch_pc low bits (value is don't-care).
- Return: when inflight_valid=1 in cycle N+1, {inflight_pc, rom_q} is pushed at that edge. Credit accounting guarantees no push into a full FIFO.
- Latency: issue in cycle N gives instr_valid in cycle N+2. Sustained throughput is 1 instruction/cycle while instr_ready=1.
- Simultaneous push and pop in one cycle: count unchanged, order preserved.
- Output stability: while instr_valid & !instr_ready, instr_data and instr_pc are held stable.
- instr_data and instr_pc reflect the FIFO head. When empty, they hold their last value (0 after reset).
- Redirect (redirect_valid=1 at edge):
  - fetch_pc<=redirect_pc; FIFO flushed (count=0); inflight_valid<=0 (in-flight rom_q discarded); no issue that cycle.
  - done<=(redirect_pc > LAST_PC).
  - A pop in the same cycle completes normally, then the flush applies.
  - First new instruction is valid 3 cycles after the redirect cycle.
- Redirect overrides done: fetch resumes from redirect_pc.
- halted = done & !inflight_valid & count==0. It is registered-state derived, with no combinational path from inputs.
- fetch_pc wraps modulo 2^32. A redirect above LAST_PC halts with no fetch.

Test Plan:
1. ROM mem[i]=0x100+i, release reset, instr_ready=1 -> instr_valid first high 2 cycles after reset release; pc 0..7 with data 0x100..0x107 on consecutive cycles; halted=1 the cycle after pc 7 is popped; rom_addr issues stop after 7.
2. instr_ready=0 for 6 cycles from first valid -> instr_data=0x100, instr_pc=0 held; count reaches DEPTH=2 with no further issue; on instr_ready=1, pcs 0,1,2,... delivered gap-free with no loss or duplication.
3. redirect_valid with redirect_pc=5 while head pc=2, instr_ready=1 -> pc 2 popped that cycle; pcs 3/4 never appear; pc 5 valid 3 cycles later, then 6, 7, then halted=1.
4. Redirect to pc=9 (> LAST_PC) mid-stream -> buffer flushed, no ROM issue, halted=1 on the cycle after the redirect edge, instr_valid=0.
5. Redirect to pc=0 while halted -> halted drops next cycle; pc 0 data 0x100 valid 3 cycles after the redirect.
6. Assert rst_n=0 asynchronously mid-stream with buffer full -> instr_valid, halted, instr_pc, instr_data go 0 immediately without a clock edge; after release, the sequence restarts at pc 0.
